// File: rtl/tile_texture_memory.sv
// Parametrised tile-texture store: a 9-cycle word-write engine on the CPU side
// and a 2-stage flipped-coordinate pixel read pipeline on the renderer side.
`timescale 1ns/1ps

module tile_texture_memory #(
    parameter int BPP           = 3,
    parameter int TILE_BITS     = 6,
    parameter int TILE_DIM_LOG2 = 3,
    localparam int PA           = TILE_BITS + 2 * TILE_DIM_LOG2,
    localparam int AW           = PA - 3,
    localparam int DEPTH        = 1 << PA
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     bus_valid,
    output logic                     bus_ready,
    input  logic [AW-1:0]            bus_addr,
    input  logic [31:0]              bus_wdata,
    input  logic [7:0]               bus_wmask,

    input  logic                     rd_valid,
    input  logic [TILE_BITS-1:0]     rd_tile,
    input  logic [TILE_DIM_LOG2-1:0] rd_x,
    input  logic [TILE_DIM_LOG2-1:0] rd_y,
    input  logic                     rd_hflip,
    input  logic                     rd_vflip,

    output logic                     px_valid,
    output logic [BPP-1:0]           px_data,
    output logic                     px_opaque
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [2:0]      lane_reg;
    logic [2:0]      lane_next;

    logic            accept;
    logic [AW-1:0]   addr_reg;
    logic [7:0]      wmask_reg;
    logic [BPP-1:0]  lane_pix_reg [8];

    logic            mem_we;
    logic [PA-1:0]   mem_waddr;
    logic [BPP-1:0]  mem_wdata;

    logic [BPP-1:0]  mem [DEPTH];

    logic            v1_reg;
    logic [PA-1:0]   rd_addr_reg;
    logic [PA-1:0]   rd_addr_next;

    logic            px_valid_reg;
    logic [BPP-1:0]  px_data_reg;
    logic            px_opaque_reg;

    // Only the low BPP bits of each 4-bit lane carry pixel data.
    logic            unused_wdata;
    assign unused_wdata = ^bus_wdata;

    // ------------------------------------------------------------------
    // Write FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            lane_reg  <= 3'd0;
        end else begin
            state_reg <= state_next;
            lane_reg  <= lane_next;
        end
    end

    // Write FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        lane_next  = lane_reg;
        case (state_reg)
            IDLE: begin
                if (bus_valid) begin
                    state_next = WRITE;
                    lane_next  = 3'd0;
                end
            end
            WRITE: begin
                lane_next = lane_reg + 3'd1;
                if (lane_reg == 3'd7) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                lane_next  = 3'd0;
            end
        endcase
    end

    // Write FSM: outputs
    always_comb begin
        bus_ready = (state_reg == IDLE);
        accept    = (state_reg == IDLE) && bus_valid;
        mem_we    = (state_reg == WRITE) && wmask_reg[lane_reg];
        mem_waddr = {addr_reg, lane_reg};
        mem_wdata = lane_pix_reg[lane_reg];
    end

    // Captured request; only meaningful while in WRITE, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_reg  <= bus_addr;
            wmask_reg <= bus_wmask;
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (accept) begin
                    lane_pix_reg[gi] <= bus_wdata[4*gi +: BPP];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pixel store (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read stage 1: flipped pixel address
    // ------------------------------------------------------------------
    always_comb begin
        rd_addr_next = {rd_tile,
                        rd_vflip ? ~rd_y : rd_y,
                        rd_hflip ? ~rd_x : rd_x};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_reg      <= 1'b0;
            rd_addr_reg <= '0;
        end else begin
            v1_reg      <= rd_valid;
            rd_addr_reg <= rd_addr_next;
        end
    end

    // ------------------------------------------------------------------
    // Read stage 2: registered memory read. Same-edge writes are not yet
    // visible here, giving read-before-write on a collision.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_valid_reg  <= 1'b0;
            px_data_reg   <= '0;
            px_opaque_reg <= 1'b0;
        end else begin
            px_valid_reg <= v1_reg;
            if (v1_reg) begin
                px_data_reg   <= mem[rd_addr_reg];
                px_opaque_reg <= (mem[rd_addr_reg] != '0);
            end
        end
    end

    assign px_valid  = px_valid_reg;
    assign px_data   = px_data_reg;
    assign px_opaque = px_opaque_reg;

endmodule
